// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared types and constants for the CDC sequence sender/receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_HI = 3'd1,
        ST_REQ_LO = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam int c_DEF_WIDTH = 4;
    localparam int c_DEF_START = 1;
    localparam int c_CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : STAGES-flop single-bit synchronizer, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_seq_sender.sv
`default_nettype none
// ============================================================================
// Module      : cdc_seq_sender
// Description : Incrementing-sequence source with four-phase req/ack CDC handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_seq_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH          = c_DEF_WIDTH,
    parameter int START_VALUE    = c_DEF_START,
    parameter int NUM_WORDS      = 0,
    parameter int GAP_CYCLES     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               err_inject,
    input  logic               ack_async,
    output logic               req,
    output logic [WIDTH-1:0]   data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [c_CNT_W-1:0] sent_count
);

    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(NUM_WORDS);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state, w_state;
    logic               r_req, w_req;
    logic [WIDTH-1:0]   r_data, w_data;
    logic [WIDTH-1:0]   r_seq, w_seq;
    logic               r_err_pend, w_err_pend;
    logic               r_done, w_done;
    logic               r_timeout, w_timeout;
    logic [c_CNT_W-1:0] r_sent, w_sent;
    logic [c_CNT_W-1:0] r_gap_cnt, w_gap_cnt;
    logic [c_CNT_W-1:0] r_to_cnt, w_to_cnt;
    logic               w_ack_sync;
    logic               w_to_expired;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (w_ack_sync)
    );

    assign w_to_expired = (TIMEOUT_CYCLES != 0) && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_state    = r_state;
        w_req      = r_req;
        w_data     = r_data;
        w_seq      = r_seq;
        w_err_pend = r_err_pend | err_inject;
        w_done     = r_done;
        w_timeout  = r_timeout;
        w_sent     = r_sent;
        w_gap_cnt  = r_gap_cnt;
        w_to_cnt   = r_to_cnt + c_CNT_W'(1);
        case (r_state)
            ST_IDLE: begin
                // A pulse arriving in the launch cycle is folded in via w_err_pend.
                if (enable && !w_ack_sync && !r_done) begin
                    w_state    = ST_REQ_HI;
                    w_req      = 1'b1;
                    w_data     = w_err_pend ? (r_seq ^ c_ONE) : r_seq;
                    w_err_pend = 1'b0;
                    w_to_cnt   = '0;
                end
            end
            ST_REQ_HI: begin
                if (w_ack_sync) begin
                    w_state  = ST_REQ_LO;
                    w_req    = 1'b0;
                    w_seq    = r_seq + c_ONE;
                    w_to_cnt = '0;
                    if (r_sent != '1) begin
                        w_sent = r_sent + c_CNT_W'(1);
                    end
                end else if (w_to_expired) begin
                    w_state   = ST_FAULT;
                    w_req     = 1'b0;
                    w_timeout = 1'b1;
                end
            end
            ST_REQ_LO: begin
                if (!w_ack_sync) begin
                    if ((NUM_WORDS != 0) && (r_sent == c_LIMIT)) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_state   = ST_GAP;
                        w_gap_cnt = '0;
                    end
                end else if (w_to_expired) begin
                    w_state   = ST_FAULT;
                    w_timeout = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state = ST_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                // DONE and FAULT hold until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_seq      <= WIDTH'(START_VALUE);
            r_err_pend <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_sent     <= '0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state;
            r_req      <= w_req;
            r_data     <= w_data;
            r_seq      <= w_seq;
            r_err_pend <= w_err_pend;
            r_done     <= w_done;
            r_timeout  <= w_timeout;
            r_sent     <= w_sent;
            r_gap_cnt  <= w_gap_cnt;
            r_to_cnt   <= w_to_cnt;
        end
    end

    assign req        = r_req;
    assign data       = r_data;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign sent_count = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_cdc_seq_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_seq_sender
// Description : Self-checking bench: responder, vector table and random model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_seq_sender;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, en_a = 1'b0, err_a = 1'b0, ack_a = 1'b0;
    logic        rst_b = 1'b0, en_b = 1'b0, err_b = 1'b0, ack_b = 1'b0;
    logic        req_a, busy_a, done_a, to_a;
    logic        req_b, busy_b, done_b, to_b;
    logic [3:0]  data_a, data_b;
    logic [15:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          dly;
        bit          inj;
        logic [3:0]  exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl[20];
    logic [3:0]  got;
    bit          ok;
    bit          seen;
    bit          pend;
    int          n_sent;
    int          n;

    always #5 clk = ~clk;

    cdc_seq_sender u_dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .err_inject(err_a), .ack_async(ack_a),
        .req(req_a), .data(data_a), .busy(busy_a), .done(done_a), .timeout(to_a),
        .sent_count(cnt_a)
    );

    cdc_seq_sender #(
        .NUM_WORDS(5), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .err_inject(err_b), .ack_async(ack_b),
        .req(req_b), .data(data_b), .busy(busy_b), .done(done_b), .timeout(to_b),
        .sent_count(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model of the sequence: word n after reset is START+n, flipped in bit 0 if corrupted.
    function automatic logic [3:0] exp_word(input int idx, input bit corrupt);
        logic [3:0] w;
        w = 4'((1 + idx) % 16);
        return corrupt ? (w ^ 4'd1) : w;
    endfunction

    function automatic bit cur_req(input bit sel);
        return sel ? req_b : req_a;
    endfunction

    // Receiver-side responder: wait req, capture data, ack after dly rx periods, release.
    task automatic respond(input bit sel, input int dly, input bit inj, input bit drop_en,
                           output logic [3:0] word, output bit good);
        int  k;
        bit  stable;
        good   = 1'b0;
        stable = 1'b1;
        word   = '0;
        k      = 0;
        while (!cur_req(sel) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!cur_req(sel)) return;
        word = sel ? data_b : data_a;
        if (inj) begin
            err_a = 1'b1;
            @(negedge clk);
            err_a = 1'b0;
        end
        if (drop_en) en_a = 1'b0;
        repeat (dly) #7;
        if (sel) ack_b = 1'b1; else ack_a = 1'b1;
        k = 0;
        while (cur_req(sel) && k < 300) begin
            if ((sel ? data_b : data_a) !== word) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        #3;
        if (sel) ack_b = 1'b0; else ack_a = 1'b0;
        good = !cur_req(sel) && stable;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 20; i++) begin
            tbl[i].dly      = (i < 17) ? 3 : (i % 4);
            tbl[i].inj      = (i == 17);
            tbl[i].exp_data = exp_word(i, i == 18);
            tbl[i].exp_cnt  = 16'(i + 1);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_timeout", 32'(to_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Stale ack blocks launch
        ack_a = 1'b1;
        repeat (4) @(negedge clk);
        en_a = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (req_a) seen = 1'b1;
        end
        chk("stale_ack_no_req", 32'(seen), 32'd0);
        ack_a = 1'b0;

        // Vector table: clean 1..15,0,1 then an injected error
        for (int i = 0; i < 20; i++) begin
            respond(1'b0, tbl[i].dly, tbl[i].inj, 1'b0, got, ok);
            chk($sformatf("tbl_ok[%0d]", i), 32'(ok), 32'd1);
            chk($sformatf("tbl_data[%0d]", i), 32'(got), 32'(tbl[i].exp_data));
            chk($sformatf("tbl_count[%0d]", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
        end
        chk("tbl_timeout", 32'(to_a), 32'd0);
        chk("tbl_done", 32'(done_a), 32'd0);

        // Enable dropped during REQ_HI: word completes, no new launch
        respond(1'b0, 3, 1'b0, 1'b1, got, ok);
        chk("en_drop_ok", 32'(ok), 32'd1);
        chk("en_drop_data", 32'(got), 32'(exp_word(20, 1'b0)));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (req_a) seen = 1'b1;
        end
        chk("en_low_no_req", 32'(seen), 32'd0);
        chk("en_low_idle", 32'(busy_a), 32'd0);
        chk("en_low_count", 32'(cnt_a), 32'd21);
        en_a = 1'b1;
        respond(1'b0, 2, 1'b0, 1'b0, got, ok);
        chk("en_back_data", 32'(got), 32'(exp_word(21, 1'b0)));

        // Randomized traffic against the sequence model
        n_sent = 22;
        pend   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bit inj;
            inj = ($urandom_range(0, 3) == 0);
            respond(1'b0, int'($urandom_range(0, 5)), inj, 1'b0, got, ok);
            chk("rnd_ok", 32'(ok), 32'd1);
            chk("rnd_data", 32'(got), 32'(exp_word(n_sent, pend)));
            n_sent++;
            pend = inj;
            chk("rnd_count", 32'(cnt_a), 32'(n_sent));
            if ($urandom_range(0, 4) == 0) begin
                en_a = 1'b0;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                en_a = 1'b1;
            end
        end

        // Async reset in the middle of word 4
        @(negedge clk);
        rst_a = 1'b0;
        #3 rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            respond(1'b0, 2, 1'b0, 1'b0, got, ok);
            chk("pre_rst_data", 32'(got), 32'(exp_word(i, 1'b0)));
        end
        n = 0;
        while (!req_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("word4_data", 32'(data_a), 32'd4);
        #2 rst_a = 1'b0;
        #1;
        chk("midrst_req", 32'(req_a), 32'd0);
        chk("midrst_data", 32'(data_a), 32'd0);
        chk("midrst_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        respond(1'b0, 2, 1'b0, 1'b0, got, ok);
        chk("post_rst_data", 32'(got), 32'd1);
        chk("post_rst_count", 32'(cnt_a), 32'd1);

        // Timeout: responder never acks
        en_b = 1'b1;
        n = 0;
        while (!req_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (req_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_req_cycles", 32'(n), 32'd20);
        chk("to_flag", 32'(to_b), 32'd1);
        chk("to_busy", 32'(busy_b), 32'd1);
        chk("to_count", 32'(cnt_b), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (req_b) seen = 1'b1;
        end
        chk("to_stays_fault", 32'(seen), 32'd0);

        // Word limit of 5
        rst_b = 1'b0;
        #1;
        chk("lim_rst_timeout", 32'(to_b), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            respond(1'b1, 2, 1'b0, 1'b0, got, ok);
            chk("lim_ok", 32'(ok), 32'd1);
            chk("lim_data", 32'(got), 32'(exp_word(i, 1'b0)));
        end
        repeat (10) @(negedge clk);
        chk("lim_done", 32'(done_b), 32'd1);
        chk("lim_busy", 32'(busy_b), 32'd0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (req_b) seen = 1'b1;
        end
        chk("lim_no_more_req", 32'(seen), 32'd0);
        chk("lim_count", 32'(cnt_b), 32'd5);
        chk("lim_timeout", 32'(to_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
